priv_status_unit: RTL and testbench
===================================

# priv_status_unit

Parametrised privilege and trap-state unit for the RV64 core. It generalises the single-mode mstatus tracker to M/S/U privilege with exception delegation, a trap-cause priority encoder, and per-mode epc/cause/tvec state. It also generates redirect targets for traps and xRET. It sits between decode/execute (trap requests, CSR writes, xRET) and fetch (redirect).

## Interface
- N, 64: XLEN, the width of all CSRs and PCs.
- NCAUSE, 16: width of the trap request vector, which is also the number of implemented exception causes.
- HAS_SMODE, 1: when 0, S-mode is absent. S fields read 0, S CSRs read 0 and ignore writes, sret is illegal, and medeleg is 0.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- trapTrigger  in  NCAUSE  exception requests; bit i means cause i.
- trapPC  in  N  PC of the trapping instruction.
- mretReturn  in  1  mret retiring this cycle.
- sretReturn  in  1  sret retiring this cycle.
- csrWriteEnable  in  1  CSR write strobe.
- csrAddr  in  12  CSR address for read and write.
- csrIn  in  N  CSR write data.
- csrOut  out  N  combinational read of csrAddr; unknown addresses read 0.
- currentMode  out  2  privilege mode: 00 U, 01 S, 11 M.
- mstatus  out  N  full mstatus register.
- redirectValid  out  1  one-cycle pulse telling fetch to redirect.
- redirectPC  out  N  redirect target, valid only with redirectValid.
- illegalReturn  out  1  one-cycle pulse for an xRET issued from an insufficient mode.

## Operation
- **CSRs and addresses:**
  - mstatus 0x300, medeleg 0x302, mtvec 0x305, mepc 0x341, mcause 0x342.
  - sstatus 0x100, which is a masked view of mstatus (SIE, SPIE, SPP only). stvec 0x105, sepc 0x141, scause 0x142.
- **mstatus fields:** SIE[1], MIE[3], SPIE[5], MPIE[7], SPP[8], MPP[12:11]. All other bits read 0.
- **WARL rules:**
  - A write of MPP=10 keeps the old MPP value. With HAS_SMODE=0, a write of MPP=01 also keeps the old value.
  - epc bit 0 is forced to 0. tvec bits[1:0] are forced to 0 (direct mode only).
  - medeleg bits ≥ NCAUSE and bit 11 are hardwired to 0.
  - cause registers hold the cause index; only bits [$clog2(NCAUSE)-1:0] are writable and all other bits read 0.
- **Write permission:** the upstream decoder has already checked privilege, so writes are accepted in every mode.
- **Trap cause:** if any trapTrigger bit is set, the cause is the index of the lowest set bit. Other pending bits are dropped; the requester re-raises them.
- **Delegation:** a trap goes to S if and only if HAS_SMODE=1, medeleg[cause]=1 and currentMode≠M. Otherwise it goes to M.
- **Trap to M:**
  - mepc←trapPC, mcause←cause.
  - MPIE←MIE, MIE←0, MPP←currentMode, mode←M.
  - redirectPC←mtvec.
- **Trap to S:**
  - sepc←trapPC, scause←cause.
  - SPIE←SIE, SIE←0, SPP←currentMode[0], mode←S.
  - redirectPC←stvec.
- **mret:**
  - Legal only in M. When legal: mode←MPP, MIE←MPIE, MPIE←1, MPP←U, redirectPC←mepc.
  - When illegal: no state change, illegalReturn=1.
- **sret:**
  - Legal only when HAS_SMODE=1 and mode∈{S,M}. When legal: mode←{0,SPP}, SIE←SPIE, SPIE←1, SPP←0, redirectPC←sepc.
  - When illegal: no state change, illegalReturn=1.
- **Priority within one cycle:** trap > mret > sret > CSR write. Lower-priority events that cycle are discarded entirely.
- **Return values:** xRET restores the epc value as it stands before any same-cycle write. Any CSR write is discarded in an xRET cycle anyway.

## Timing
- **Reset (async, immediate):**
  - currentMode=11; mstatus=0; all other CSRs 0.
  - redirectValid=0, redirectPC=0, illegalReturn=0.
- **State latency:** all state updates on the rising clk edge. currentMode, mstatus and CSRs reflect an event one cycle after it is sampled.
- **Redirect timing:** redirectValid and redirectPC are registered. They assert in the cycle after the sampled trap or legal xRET and last exactly one cycle. Back-to-back events produce back-to-back pulses.
- **illegalReturn:** registered, one cycle, same timing as redirectValid. It is never asserted together with redirectValid.
- **Held inputs:** a trapTrigger held high for k cycles takes k traps, one per cycle. Each trap re-saves MPP/MPIE from the state left by the previous one.
- **csrOut:** combinational. It reflects writes from the cycle after the write edge.
- **Reset during a trap or return:** reset mid-trap or mid-return wins. No partial update is left and any pending redirect pulse is cleared.

## Test plan
- **Reset and M-mode trap:**
  - Reset, mtvec←0x8000_0100, set MIE, then pulse trapTrigger=0x0004 with trapPC=0x1230.
  - Required next cycle: redirectValid=1, redirectPC=0x8000_0100, mcause=2, mepc=0x1230, MIE=0, MPIE=1, MPP=11, currentMode=11.
- **Delegation:**
  - Set medeleg=0x0100, stvec=0x4000, MPP=00, then mret into U. Pulse trapTrigger=0x0100 with trapPC=0x2000.
  - Required: currentMode=01, scause=8, sepc=0x2000, SPP=0, redirectPC=0x4000, mcause unchanged.
- **Priority encoding and non-delegation in M:** with currentMode=11 and medeleg=0xFFFF, trapTrigger=0x0120.
  - Required: trap to M with cause 5. mepc is written and sepc is unchanged.
- **Illegal return and same-cycle priority:**
  - mret in U → illegalReturn=1 for 1 cycle, no mode or mstatus change.
  - trapTrigger with mretReturn and a CSR write to mtvec in the same cycle → only the trap takes effect; mtvec is unchanged.
- **WARL masking:**
  - Write mstatus=0xFFFF_FFFF_FFFF_FFFF, then read back 0x19AA.
  - Write MPP=10 → MPP retains 11.
  - With HAS_SMODE=0, MPP=01 is rejected and sret gives illegalReturn=1.
- **Async reset mid-redirect:** assert reset between the trap edge and the next edge.
  - Required: redirectValid=0 immediately, currentMode=11, mstatus=0.

Source files
------------

// File: rtl/priv_status_unit_if.sv
// Signal bundle between decode/execute, fetch and the privilege/trap-state unit.
interface priv_status_unit_if #(
    parameter int unsigned N      = 64,
    parameter int unsigned NCAUSE = 16
);
    logic [NCAUSE-1:0] trapTrigger;
    logic [N-1:0]      trapPC;
    logic              mretReturn;
    logic              sretReturn;
    logic              csrWriteEnable;
    logic [11:0]       csrAddr;
    logic [N-1:0]      csrIn;
    logic [N-1:0]      csrOut;
    logic [1:0]        currentMode;
    logic [N-1:0]      mstatus;
    logic              redirectValid;
    logic [N-1:0]      redirectPC;
    logic              illegalReturn;

    modport master (
        output trapTrigger, trapPC, mretReturn, sretReturn, csrWriteEnable, csrAddr, csrIn,
        input  csrOut, currentMode, mstatus, redirectValid, redirectPC, illegalReturn
    );

    modport slave (
        input  trapTrigger, trapPC, mretReturn, sretReturn, csrWriteEnable, csrAddr, csrIn,
        output csrOut, currentMode, mstatus, redirectValid, redirectPC, illegalReturn
    );
endinterface

// File: rtl/priv_status_unit.sv
// M/S/U privilege and trap-state unit: trap delegation, cause encoding, xRET and
// per-mode epc/cause/tvec CSRs, with registered fetch redirect.
module priv_status_unit #(
    parameter int unsigned N         = 64,
    parameter int unsigned NCAUSE    = 16,
    parameter bit          HAS_SMODE = 1'b1
) (
    input logic               clk,
    input logic               reset,
    priv_status_unit_if.slave bus
);
    localparam int unsigned CW        = (NCAUSE > 1) ? $clog2(NCAUSE) : 1;
    localparam logic [N-1:0] EPC_MASK  = ~N'(1);
    localparam logic [N-1:0] TVEC_MASK = ~N'(3);

    typedef enum logic [1:0] {
        MODE_U = 2'b00,
        MODE_S = 2'b01,
        MODE_M = 2'b11
    } mode_t;

    mode_t         mode;
    logic          sie, mie, spie, mpie, spp;
    logic [1:0]    mpp;
    logic [N-1:0]  medeleg, mtvec, mepc, stvec, sepc;
    logic [CW-1:0] mcause, scause;
    logic          redirect_valid, illegal_return;
    logic [N-1:0]  redirect_pc;

    logic [N-1:0]  deleg_mask;
    logic [N-1:0]  mstatus_val, sstatus_val, csr_rd;
    logic [CW-1:0] cause;
    logic          found, trap_any, to_s, mret_ok, sret_ok;
    logic [1:0]    mpp_wr;

    always_comb begin
        deleg_mask = '0;
        for (int unsigned i = 0; i < N; i++)
            if (HAS_SMODE && i < NCAUSE && i != 11) deleg_mask[i] = 1'b1;
    end

    // Lowest set request bit wins; the rest are dropped for the requester to re-raise.
    always_comb begin
        cause = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NCAUSE; i++) begin
            if (bus.trapTrigger[i] && !found) begin
                cause = CW'(i);
                found = 1'b1;
            end
        end
    end

    assign trap_any = |bus.trapTrigger;
    assign to_s     = HAS_SMODE && medeleg[cause] && (mode != MODE_M);
    assign mret_ok  = (mode == MODE_M);
    assign sret_ok  = HAS_SMODE && (mode != MODE_U);

    always_comb begin
        mpp_wr = bus.csrIn[12:11];
        if (mpp_wr == 2'b10 || (!HAS_SMODE && mpp_wr == 2'b01)) mpp_wr = mpp;
    end

    always_comb begin
        mstatus_val        = '0;
        mstatus_val[1]     = sie;
        mstatus_val[3]     = mie;
        mstatus_val[5]     = spie;
        mstatus_val[7]     = mpie;
        mstatus_val[8]     = spp;
        mstatus_val[12:11] = mpp;
        sstatus_val        = '0;
        sstatus_val[1]     = sie;
        sstatus_val[5]     = spie;
        sstatus_val[8]     = spp;
    end

    always_comb begin
        csr_rd = '0;
        case (bus.csrAddr)
            12'h300: csr_rd = mstatus_val;
            12'h302: csr_rd = medeleg;
            12'h305: csr_rd = mtvec;
            12'h341: csr_rd = mepc;
            12'h342: csr_rd = N'(mcause);
            12'h100: if (HAS_SMODE) csr_rd = sstatus_val;
            12'h105: if (HAS_SMODE) csr_rd = stvec;
            12'h141: if (HAS_SMODE) csr_rd = sepc;
            12'h142: if (HAS_SMODE) csr_rd = N'(scause);
            default: csr_rd = '0;
        endcase
    end

    // Events are mutually exclusive per cycle: trap, then mret, then sret, then CSR write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode           <= MODE_M;
            sie            <= 1'b0;
            mie            <= 1'b0;
            spie           <= 1'b0;
            mpie           <= 1'b0;
            spp            <= 1'b0;
            mpp            <= 2'b00;
            medeleg        <= '0;
            mtvec          <= '0;
            mepc           <= '0;
            stvec          <= '0;
            sepc           <= '0;
            mcause         <= '0;
            scause         <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            illegal_return <= 1'b0;
        end else begin
            redirect_valid <= 1'b0;
            illegal_return <= 1'b0;
            if (trap_any) begin
                redirect_valid <= 1'b1;
                if (to_s) begin
                    sepc        <= bus.trapPC & EPC_MASK;
                    scause      <= cause;
                    spie        <= sie;
                    sie         <= 1'b0;
                    spp         <= mode[0];
                    mode        <= MODE_S;
                    redirect_pc <= stvec;
                end else begin
                    mepc        <= bus.trapPC & EPC_MASK;
                    mcause      <= cause;
                    mpie        <= mie;
                    mie         <= 1'b0;
                    mpp         <= mode;
                    mode        <= MODE_M;
                    redirect_pc <= mtvec;
                end
            end else if (bus.mretReturn) begin
                if (mret_ok) begin
                    mode           <= mode_t'(mpp);
                    mie            <= mpie;
                    mpie           <= 1'b1;
                    mpp            <= MODE_U;
                    redirect_pc    <= mepc;
                    redirect_valid <= 1'b1;
                end else begin
                    illegal_return <= 1'b1;
                end
            end else if (bus.sretReturn) begin
                if (sret_ok) begin
                    mode           <= spp ? MODE_S : MODE_U;
                    sie            <= spie;
                    spie           <= 1'b1;
                    spp            <= 1'b0;
                    redirect_pc    <= sepc;
                    redirect_valid <= 1'b1;
                end else begin
                    illegal_return <= 1'b1;
                end
            end else if (bus.csrWriteEnable) begin
                case (bus.csrAddr)
                    12'h300: begin
                        mie  <= bus.csrIn[3];
                        mpie <= bus.csrIn[7];
                        mpp  <= mpp_wr;
                        if (HAS_SMODE) begin
                            sie  <= bus.csrIn[1];
                            spie <= bus.csrIn[5];
                            spp  <= bus.csrIn[8];
                        end
                    end
                    12'h302: medeleg <= bus.csrIn & deleg_mask;
                    12'h305: mtvec   <= bus.csrIn & TVEC_MASK;
                    12'h341: mepc    <= bus.csrIn & EPC_MASK;
                    12'h342: mcause  <= bus.csrIn[CW-1:0];
                    12'h100: if (HAS_SMODE) begin
                        sie  <= bus.csrIn[1];
                        spie <= bus.csrIn[5];
                        spp  <= bus.csrIn[8];
                    end
                    12'h105: if (HAS_SMODE) stvec  <= bus.csrIn & TVEC_MASK;
                    12'h141: if (HAS_SMODE) sepc   <= bus.csrIn & EPC_MASK;
                    12'h142: if (HAS_SMODE) scause <= bus.csrIn[CW-1:0];
                    default: ;
                endcase
            end
        end
    end

    assign bus.csrOut        = csr_rd;
    assign bus.currentMode   = mode;
    assign bus.mstatus       = mstatus_val;
    assign bus.redirectValid = redirect_valid;
    assign bus.redirectPC    = redirect_pc;
    assign bus.illegalReturn = illegal_return;
endmodule

// File: tb/tb_priv_status_unit.sv
// Directed bench: a CSR-map model checks the S-capable unit every cycle; an
// M/U-only instance is checked with literal expectations.
module tb_priv_status_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    priv_status_unit_if #(.N(64), .NCAUSE(16)) a_if ();
    priv_status_unit_if #(.N(64), .NCAUSE(16)) b_if ();

    priv_status_unit #(.N(64), .NCAUSE(16), .HAS_SMODE(1'b1)) dut_a (
        .clk(clk), .reset(rst), .bus(a_if.slave));
    priv_status_unit #(.N(64), .NCAUSE(16), .HAS_SMODE(1'b0)) dut_b (
        .clk(clk), .reset(rst), .bus(b_if.slave));

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    // Model: the CSR file as plain values, mstatus kept as the architectural word.
    logic [63:0] ms, medeleg, mtvec, mepc, mcause, stvec, sepc, scause;
    int          mode;
    logic        exp_rv, exp_ill;
    logic [63:0] exp_rpc;
    int          c;

    function automatic logic [63:0] model_read(input logic [11:0] ad);
        case (ad)
            12'h300: return ms;
            12'h302: return medeleg;
            12'h305: return mtvec;
            12'h341: return mepc;
            12'h342: return mcause;
            12'h100: return ms & 64'h122;
            12'h105: return stvec;
            12'h141: return sepc;
            12'h142: return scause;
            default: return 64'h0;
        endcase
    endfunction

    task automatic model_write(input logic [11:0] ad, input logic [63:0] v);
        logic [63:0] nv;
        case (ad)
            12'h300: begin
                nv = v & 64'h19AA;
                if (v[12:11] == 2'b10) nv[12:11] = ms[12:11];
                ms = nv;
            end
            12'h100: ms = (ms & ~64'h122) | (v & 64'h122);
            12'h302: medeleg = v & 64'hF7FF;
            12'h305: mtvec = v & ~64'h3;
            12'h341: mepc = v & ~64'h1;
            12'h342: mcause = v % 16;
            12'h105: stvec = v & ~64'h3;
            12'h141: sepc = v & ~64'h1;
            12'h142: scause = v % 16;
            default: ;
        endcase
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ms = 0; medeleg = 0; mtvec = 0; mepc = 0; mcause = 0;
            stvec = 0; sepc = 0; scause = 0; mode = 3;
            exp_rv = 0; exp_ill = 0; exp_rpc = 0;
        end else begin
            exp_rv = 0;
            exp_ill = 0;
            if (a_if.trapTrigger != 0) begin
                c = 0;
                while (!a_if.trapTrigger[c]) c++;
                if (medeleg[c] && mode != 3) begin
                    sepc = a_if.trapPC & ~64'h1; scause = c;
                    ms[5] = ms[1]; ms[1] = 0; ms[8] = (mode == 1);
                    mode = 1; exp_rpc = stvec;
                end else begin
                    mepc = a_if.trapPC & ~64'h1; mcause = c;
                    ms[7] = ms[3]; ms[3] = 0; ms[12:11] = 2'(mode);
                    mode = 3; exp_rpc = mtvec;
                end
                exp_rv = 1;
            end else if (a_if.mretReturn) begin
                if (mode == 3) begin
                    mode = int'(ms[12:11]); ms[3] = ms[7]; ms[7] = 1; ms[12:11] = 0;
                    exp_rpc = mepc; exp_rv = 1;
                end else exp_ill = 1;
            end else if (a_if.sretReturn) begin
                if (mode != 0) begin
                    mode = ms[8] ? 1 : 0; ms[1] = ms[5]; ms[5] = 1; ms[8] = 0;
                    exp_rpc = sepc; exp_rv = 1;
                end else exp_ill = 1;
            end else if (a_if.csrWriteEnable) begin
                model_write(a_if.csrAddr, a_if.csrIn);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("mode", 64'(a_if.currentMode), 64'(mode));
            check("mstatus", a_if.mstatus, ms);
            check("redirectValid", 64'(a_if.redirectValid), 64'(exp_rv));
            check("illegalReturn", 64'(a_if.illegalReturn), 64'(exp_ill));
            if (exp_rv) check("redirectPC", a_if.redirectPC, exp_rpc);
        end
    end

    task automatic idle();
        a_if.trapTrigger = '0; a_if.trapPC = '0; a_if.mretReturn = 0; a_if.sretReturn = 0;
        a_if.csrWriteEnable = 0; a_if.csrAddr = '0; a_if.csrIn = '0;
        b_if.trapTrigger = '0; b_if.trapPC = '0; b_if.mretReturn = 0; b_if.sretReturn = 0;
        b_if.csrWriteEnable = 0; b_if.csrAddr = '0; b_if.csrIn = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [11:0] ad, input logic [63:0] v);
        a_if.csrWriteEnable = 1; a_if.csrAddr = ad; a_if.csrIn = v;
        tick(); idle();
    endtask

    task automatic trap(input logic [15:0] t, input logic [63:0] pc);
        a_if.trapTrigger = t; a_if.trapPC = pc;
        tick(); idle();
    endtask

    task automatic rd(input logic [11:0] ad, input logic [63:0] lit, input string name);
        a_if.csrAddr = ad;
        #1;
        check(name, a_if.csrOut, lit);
        check({name, "_model"}, model_read(ad), lit);
    endtask

    task automatic rdb(input logic [11:0] ad, input logic [63:0] lit, input string name);
        b_if.csrAddr = ad;
        #1;
        check(name, b_if.csrOut, lit);
    endtask

    initial begin
        idle();
        #1 rst = 1;
        #1;
        chk_en = 1;
        check("rst_mode", 64'(a_if.currentMode), 64'h3);
        check("rst_mstatus", a_if.mstatus, 64'h0);
        check("rst_rv", 64'(a_if.redirectValid), 64'h0);
        check("rst_rpc", a_if.redirectPC, 64'h0);
        rd(12'h305, 64'h0, "rst_mtvec");
        rd(12'h341, 64'h0, "rst_mepc");
        #20 rst = 0;
        tick();

        // M-mode trap
        wr(12'h305, 64'h8000_0100);
        wr(12'h300, 64'h8);
        trap(16'h0004, 64'h1230);
        check("mtrap_rv", 64'(a_if.redirectValid), 64'h1);
        check("mtrap_rpc", a_if.redirectPC, 64'h8000_0100);
        check("mtrap_mstatus", a_if.mstatus, 64'h1880);
        check("mtrap_mode", 64'(a_if.currentMode), 64'h3);
        rd(12'h342, 64'h2, "mtrap_mcause");
        rd(12'h341, 64'h1230, "mtrap_mepc");
        tick();
        check("mtrap_pulse_end", 64'(a_if.redirectValid), 64'h0);

        // Delegation from U to S
        wr(12'h302, 64'h0100);
        wr(12'h105, 64'h4000);
        wr(12'h300, 64'h0);
        a_if.mretReturn = 1; tick(); idle();
        check("mret_mode", 64'(a_if.currentMode), 64'h0);
        check("mret_rpc", a_if.redirectPC, 64'h1230);
        check("mret_mstatus", a_if.mstatus, 64'h80);
        trap(16'h0100, 64'h2000);
        check("deleg_mode", 64'(a_if.currentMode), 64'h1);
        check("deleg_rpc", a_if.redirectPC, 64'h4000);
        check("deleg_spp", 64'(a_if.mstatus[8]), 64'h0);
        rd(12'h142, 64'h8, "deleg_scause");
        rd(12'h141, 64'h2000, "deleg_sepc");
        rd(12'h342, 64'h2, "deleg_mcause_kept");

        // sret to U, then illegal xRETs from U
        a_if.sretReturn = 1; tick(); idle();
        check("sret_mode", 64'(a_if.currentMode), 64'h0);
        check("sret_mstatus", a_if.mstatus, 64'hA0);
        a_if.mretReturn = 1; tick(); idle();
        check("ill_mret", 64'(a_if.illegalReturn), 64'h1);
        check("ill_mret_rv", 64'(a_if.redirectValid), 64'h0);
        check("ill_mret_mode", 64'(a_if.currentMode), 64'h0);
        check("ill_mret_mstatus", a_if.mstatus, 64'hA0);
        a_if.sretReturn = 1; tick(); idle();
        check("ill_sret", 64'(a_if.illegalReturn), 64'h1);
        tick();
        check("ill_pulse_end", 64'(a_if.illegalReturn), 64'h0);

        // Priority encoding, no delegation while in M
        trap(16'h0001, 64'h3000);
        check("u2m_mstatus", a_if.mstatus, 64'h20);
        wr(12'h302, 64'hFFFF);
        rd(12'h302, 64'hF7FF, "medeleg_warl");
        trap(16'h0120, 64'h5000);
        check("prio_mode", 64'(a_if.currentMode), 64'h3);
        check("prio_mstatus", a_if.mstatus, 64'h1820);
        rd(12'h342, 64'h5, "prio_mcause");
        rd(12'h341, 64'h5000, "prio_mepc");
        rd(12'h141, 64'h2000, "prio_sepc_kept");

        // Same-cycle trap + mret + CSR write: only the trap lands
        a_if.trapTrigger = 16'h0008; a_if.trapPC = 64'h6000; a_if.mretReturn = 1;
        a_if.csrWriteEnable = 1; a_if.csrAddr = 12'h305; a_if.csrIn = 64'h9999_0000;
        tick(); idle();
        check("same_rpc", a_if.redirectPC, 64'h8000_0100);
        rd(12'h305, 64'h8000_0100, "same_mtvec_kept");
        rd(12'h342, 64'h3, "same_mcause");
        // mret with a same-cycle mepc write returns to the old mepc
        a_if.mretReturn = 1; a_if.csrWriteEnable = 1; a_if.csrAddr = 12'h341; a_if.csrIn = 64'h7770;
        tick(); idle();
        check("mretw_rpc", a_if.redirectPC, 64'h6000);
        check("mretw_mstatus", a_if.mstatus, 64'hA0);
        rd(12'h341, 64'h6000, "mretw_mepc_kept");

        // Held trigger: one trap per cycle
        a_if.trapTrigger = 16'h0002; a_if.trapPC = 64'h7000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("held_rv", 64'(a_if.redirectValid), 64'h1);
        end
        idle();
        tick();
        check("held_mstatus", a_if.mstatus, 64'h1820);

        // WARL
        wr(12'h300, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(12'h300, 64'h19AA, "warl_all_ones");
        wr(12'h300, 64'h1000);
        rd(12'h300, 64'h1800, "warl_mpp10");
        wr(12'h341, 64'hFFF);
        rd(12'h341, 64'hFFE, "warl_mepc");
        wr(12'h305, 64'h123);
        rd(12'h305, 64'h120, "warl_mtvec");
        wr(12'h342, 64'hFFFF_FFFF);
        rd(12'h342, 64'hF, "warl_mcause");
        wr(12'h100, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(12'h100, 64'h122, "warl_sstatus");
        rd(12'h300, 64'h1922, "warl_sstatus_in_mstatus");
        wr(12'h142, 64'h35);
        rd(12'h142, 64'h5, "warl_scause");
        rd(12'h7C0, 64'h0, "unknown_addr");

        // Instance without S-mode
        b_if.csrWriteEnable = 1; b_if.csrAddr = 12'h300; b_if.csrIn = 64'h1800; tick(); idle();
        b_if.csrWriteEnable = 1; b_if.csrAddr = 12'h300; b_if.csrIn = 64'h0800; tick(); idle();
        rdb(12'h300, 64'h1800, "nos_mpp01");
        b_if.csrWriteEnable = 1; b_if.csrAddr = 12'h300; b_if.csrIn = '1; tick(); idle();
        rdb(12'h300, 64'h1888, "nos_all_ones");
        b_if.csrWriteEnable = 1; b_if.csrAddr = 12'h302; b_if.csrIn = 64'hFFFF; tick(); idle();
        rdb(12'h302, 64'h0, "nos_medeleg");
        b_if.csrWriteEnable = 1; b_if.csrAddr = 12'h105; b_if.csrIn = 64'h4000; tick(); idle();
        rdb(12'h105, 64'h0, "nos_stvec");
        rdb(12'h100, 64'h0, "nos_sstatus");
        b_if.sretReturn = 1; tick(); idle();
        check("nos_sret_ill", 64'(b_if.illegalReturn), 64'h1);
        check("nos_sret_rv", 64'(b_if.redirectValid), 64'h0);
        check("nos_mode", 64'(b_if.currentMode), 64'h3);

        // Async reset between the trap edge and the following edge
        trap(16'h0004, 64'h8000);
        check("pre_rst_rv", 64'(a_if.redirectValid), 64'h1);
        rst = 1;
        #1;
        check("mid_rst_rv", 64'(a_if.redirectValid), 64'h0);
        check("mid_rst_mode", 64'(a_if.currentMode), 64'h3);
        check("mid_rst_mstatus", a_if.mstatus, 64'h0);
        rd(12'h341, 64'h0, "mid_rst_mepc");
        rst = 0;
        tick();
        tick();

        chk_en = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
